interconnect_rx: RTL
====================

Name: interconnect_rx

Overview:
- Receiving end of the 8-bit board-to-board button interconnect.
- The sender drives interconnect = {3'b111, btn[4:0]}. Buttons are active-low, and the idle bus is 8'hFF.
- This block synchronises the bus, qualifies the link on the 3'b111 marker, debounces the five button lines, and queues press/release events in a small FIFO with a valid/ready handshake.
- It sits on the receiving FPGA between the header pins and the game/UI logic.

Parameters:
- DEBOUNCE_CYCLES, 48000: consecutive cycles a raw button level must differ from the stable level before the stable level updates (≥2).
- LINK_CYCLES, 96000: consecutive cycles the marker must read 3'b111 before link_ok asserts (≥2).
- FIFO_DEPTH, 4: number of event entries; must be a power of two, ≥2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- interconnect  in  8  raw bus from the sender; asynchronous to clk
- link_ok  out  1  marker qualified
- btn_state  out  5  debounced button levels; 1 = pressed
- ev_valid  out  1  FIFO head valid
- ev_ready  in  1  consumer accepts the head
- ev_data  out  10  [9:5] newly-pressed mask, [4:0] newly-released mask
- ev_overflow  out  1  sticky: an event was dropped
- ovf_clr  in  1  clears ev_overflow

Behaviour:
- Reset (rst_n low, asynchronous):
  - Synchroniser flops = 8'hFF.
  - link_ok = 0, btn_state = 0, ev_valid = 0, ev_data = 0, ev_overflow = 0.
  - All counters cleared; FIFO empty.
- Synchroniser: two flops on all 8 bits, so 2 cycles of latency to the "sync" value. All logic below uses only sync.
- Link qualifier:
  - A counter increments while sync[7:5] == 3'b111 and saturates at LINK_CYCLES.
  - link_ok = 1 when the counter equals LINK_CYCLES.
  - Any cycle with sync[7:5] != 3'b111 clears the counter, and link_ok drops on the next clock edge.
- Link loss (link_ok 1→0):
  - btn_state forced to 0 and debounce counters cleared.
  - FIFO flushed (ev_valid = 0 the next cycle).
  - No events are generated for the forced release.
  - ev_overflow is unaffected.
- Debounce, per bit i, only while link_ok = 1:
  - raw_i = ~sync[i].
  - If raw_i == btn_state[i], cnt_i <= 0.
  - Otherwise cnt_i increments. When cnt_i == DEBOUNCE_CYCLES-1, btn_state[i] <= raw_i and cnt_i <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES never changes btn_state.
  - Counter width = clog2(DEBOUNCE_CYCLES).
- Event generation:
  - In any cycle where btn_state changes, one entry is pushed: pressed mask = new & ~old, released mask = old & ~new.
  - Bits changing in the same cycle share one entry.
  - There is at most one push per cycle.
- FIFO:
  - ev_data/ev_valid present the head combinationally from storage; pop occurs when ev_valid & ev_ready.
  - Push is accepted when not full, or when full with a pop in the same cycle.
  - Push while full with no pop: the entry is dropped and ev_overflow <= 1.
  - Push and pop when empty: not allowed to bypass; ev_valid rises the cycle after the push.
  - ev_data is held stable while ev_valid & ~ev_ready.
  - Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit.
- Overflow flag: ovf_clr clears ev_overflow. If ovf_clr and a new drop occur in the same cycle, the drop wins (flag = 1).
- Total latency, pin edge to ev_valid: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.

Test Plan (bench uses DEBOUNCE_CYCLES=4, LINK_CYCLES=8, FIFO_DEPTH=4):
1. Reset and link-up:
   - Hold interconnect=8'hFF; release rst_n → link_ok=1 exactly 2+8 cycles later; btn_state=0; ev_valid=0.
   - Drive 8'h1F → link_ok=0 within 3 cycles.
2. Press/release:
   - With link up, drive 8'hFE (btn0 pressed) → btn_state=5'b00001 and ev_valid=1 with ev_data=10'b00001_00000 after 2+4+1 cycles.
   - Pulse ev_ready → ev_valid=0.
   - Return to 8'hFF → ev_data=10'b00000_00001.
3. Glitch rejection: pulse 8'hFD for 3 cycles, then 8'hFF → btn_state unchanged and no event.
4. Simultaneous edges: 8'hFF→8'hE0 (all five pressed) → single entry, ev_data=10'b11111_00000.
5. Overflow:
   - ev_ready=0; generate 5 distinct events → 4 queued; ev_overflow=1; head is the first event, held stable.
   - Drain 4 entries in order.
   - Pulse ovf_clr → ev_overflow=0.
   - Full with ev_ready=1 and a new push in the same cycle → no drop.
6. Link loss mid-operation:
   - Buttons pressed and 2 events queued; drive marker 3'b011 → link_ok=0, btn_state=0, ev_valid=0, no new events.
   - Restore 8'hFF → link re-qualifies after 8 cycles.
   - Assert rst_n low mid-debounce → all outputs return to reset values immediately.

Source files
------------

// File: rtl/interconnect_rx.sv
// rtl/interconnect_rx.sv - board-to-board button interconnect receiver
// Synchronises the bus, qualifies the link, debounces five buttons and queues edge events.
module interconnect_rx #(
    parameter int DEBOUNCE_CYCLES = 48000,
    parameter int LINK_CYCLES     = 96000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] interconnect_i,
    output logic       link_ok_o,
    output logic [4:0] btn_state_o,
    output logic       ev_valid_o,
    input  logic       ev_ready_i,
    output logic [9:0] ev_data_o,
    output logic       ev_overflow_o,
    input  logic       ovf_clr_i
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int LW = $clog2(LINK_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]    sync1_q, sync_q;
    logic [1:0]    fill_q, fill_d;
    logic [LW-1:0] link_cnt_q, link_cnt_d;
    logic [4:0]    btn_q, btn_d, prev_q, prev_d, raw;
    logic [DW-1:0] db_cnt_q [5];
    logic [DW-1:0] db_cnt_d [5];
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic          ovf_q, ovf_d;
    logic          link_ok, empty, full, pop, push_req, push_ok, drop;

    // The reset value of the synchroniser is not an observation of the bus,
    // so the link counter waits until both stages hold sampled data.
    always_comb begin
        fill_d     = {fill_q[0], 1'b1};
        link_cnt_d = link_cnt_q;
        if (sync_q[7:5] != 3'b111 || fill_q != 2'b11)
            link_cnt_d = '0;
        else if (link_cnt_q != LW'(LINK_CYCLES))
            link_cnt_d = link_cnt_q + 1'b1;
    end

    assign link_ok = (link_cnt_q == LW'(LINK_CYCLES));
    assign raw     = ~sync_q[4:0];

    always_comb begin
        btn_d  = btn_q;
        prev_d = link_ok ? btn_q : 5'b0;
        for (int i = 0; i < 5; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (!link_ok) begin
                db_cnt_d[i] = '0;
                btn_d[i]    = 1'b0;
            end else if (raw[i] == btn_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                btn_d[i]    = raw[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop      = !empty && ev_ready_i;
    assign push_req = link_ok && (btn_q != prev_q);
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_comb begin
        wr_d  = link_ok ? wr_q + (AW + 1)'(push_ok) : '0;
        rd_d  = link_ok ? rd_q + (AW + 1)'(pop) : '0;
        ovf_d = drop ? 1'b1 : (ovf_clr_i ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q    <= 8'hFF;
            sync_q     <= 8'hFF;
            fill_q     <= '0;
            link_cnt_q <= '0;
            btn_q      <= '0;
            prev_q     <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < 5; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q    <= interconnect_i;
            sync_q     <= sync1_q;
            fill_q     <= fill_d;
            link_cnt_q <= link_cnt_d;
            btn_q      <= btn_d;
            prev_q     <= prev_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            ovf_q      <= ovf_d;
            for (int i = 0; i < 5; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok)
            mem_q[wr_q[AW-1:0]] <= {btn_q & ~prev_q, prev_q & ~btn_q};
    end

    assign link_ok_o     = link_ok;
    assign btn_state_o   = btn_q;
    assign ev_valid_o    = !empty;
    assign ev_data_o     = empty ? 10'b0 : mem_q[rd_q[AW-1:0]];
    assign ev_overflow_o = ovf_q;

endmodule
